// File: rtl/regfile_dump_if.sv
// Beat stream carrying one captured register per transfer from regfile_dump to its consumer.
// A beat is accepted at a rising edge where out_valid and out_ready are both high. The payload is held until then.
interface regfile_dump_if #(
   parameter int WIDTH = 64,
   parameter int AW    = 5
) ();
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [AW-1:0]    out_index;
   logic             out_last;

   modport master (output out_valid, out_data, out_index, out_last, input out_ready);
   modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Debug read-out sequencer: sweeps the register file read port and streams one beat per register.
// Optional macro REGFILE_DUMP_SKIP_ZR_EN drops the zero register (last index) from the dump.
module regfile_dump #(
   parameter int NREGS = 32,
   parameter int WIDTH = 64,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    ra,
   input  logic [WIDTH-1:0] rd,
   output logic [1:0]       dbg_state,
   regfile_dump_if.master   dump
);

`ifdef REGFILE_DUMP_SKIP_ZR_EN
   localparam int LAST = NREGS - 2;
`else
   localparam int LAST = NREGS - 1;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;

   state_t        state;
   logic [AW-1:0] idx;

   // Address depends on state only, so out_ready never reaches ra or out_data combinationally.
   assign ra        = (state == LOAD || state == SEND) ? idx : '0;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         idx            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         dump.out_valid <= 1'b0;
         dump.out_data  <= '0;
         dump.out_index <= '0;
         dump.out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               dump.out_data  <= rd;
               dump.out_index <= idx;
               dump.out_last  <= (idx == AW'(LAST));
               dump.out_valid <= 1'b1;
               state          <= SEND;
            end
            SEND: begin
               if (dump.out_ready) begin
                  dump.out_valid <= 1'b0;
                  if (dump.out_last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx   <= idx + AW'(1);
                     state <= LOAD;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: register file model, scoreboard of expected beats, directed scenarios.
module tb_regfile_dump;
   localparam int NREGS = 32;
   localparam int WIDTH = 64;
   localparam int AW    = 5;
`ifdef REGFILE_DUMP_SKIP_ZR_EN
   localparam int LAST = NREGS - 2;
`else
   localparam int LAST = NREGS - 1;
`endif
   localparam int EW = 1 + AW + WIDTH;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             busy, done;
   logic [AW-1:0]    ra;
   logic [WIDTH-1:0] rd;
   logic [1:0]       dbg_state;
   logic [WIDTH-1:0] regs [NREGS];

   logic [EW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   logic last_pend = 1'b0;

   regfile_dump_if #(.WIDTH(WIDTH), .AW(AW)) dut_if ();

   regfile_dump #(.NREGS(NREGS), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
      .ra(ra), .rd(rd), .dbg_state(dbg_state), .dump(dut_if.master)
   );

   assign rd = regs[ra];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_dump(input logic dead5);
      logic [WIDTH-1:0] v;
      for (int i = 0; i <= LAST; i++) begin
         v = (i == NREGS - 1) ? '0 : WIDTH'(i);
         if (dead5 && i == 5) v = 64'hDEAD;
         exp_q.push_back({(i == LAST), AW'(i), v});
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_beat(input int idx);
      int n = 0;
      while (!(dut_if.out_valid && dut_if.out_index == AW'(idx)) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("wait_beat_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check("wait_done_timeout", 0, 1);
      tick();
   endtask

   // Scoreboard: a beat is accepted at the next edge when valid and ready are seen high here.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      logic acc_last;
      acc_last = 1'b0;
      if (reset_n && dut_if.out_valid && dut_if.out_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", EW'(dut_if.out_index), '1);
         end else begin
            e = exp_q.pop_front();
            check("beat", {dut_if.out_last, dut_if.out_index, dut_if.out_data}, e);
         end
         acc_last = dut_if.out_last;
      end
      if (done) done_cnt++;
      if (done || last_pend) check("done_pulse", EW'(done), EW'(last_pend));
      last_pend = acc_last;
   end

   initial begin
      int cyc, busy_cyc, dc;
      for (int i = 0; i < NREGS; i++) regs[i] = (i == NREGS - 1) ? '0 : WIDTH'(i);
      dut_if.out_ready = 1'b1;

      // Reset state
      tick(); tick();
      check("rst_busy", EW'(busy), 0);
      check("rst_done", EW'(done), 0);
      check("rst_ra", EW'(ra), 0);
      check("rst_valid", EW'(dut_if.out_valid), 0);
      check("rst_data", EW'(dut_if.out_data), 0);
      check("rst_index", EW'(dut_if.out_index), 0);
      check("rst_last", EW'(dut_if.out_last), 0);
      check("rst_state", EW'(dbg_state), 0);
      reset_n = 1'b1;
      tick();

      // Full dump with ready high: latency and cycle counts
      push_dump(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("load_busy", EW'(busy), 1);
      check("load_valid", EW'(dut_if.out_valid), 0);
      check("load_state", EW'(dbg_state), 1);
      check("load_ra", EW'(ra), 0);
      busy_cyc = 1;
      cyc = 0;
      tick();
      cyc++;
      check("first_valid", EW'(dut_if.out_valid), 1);
      check("first_index", EW'(dut_if.out_index), 0);
      while (!done && cyc < 300) begin
         if (busy) busy_cyc++;
         tick();
         cyc++;
      end
      check("dump_cycles", EW'(cyc), EW'(2 * (LAST + 1)));
      check("busy_cycles", EW'(busy_cyc), EW'(2 * (LAST + 1)));
      check("done_busy", EW'(busy), 0);
      tick();
      check("done_one_cycle", EW'(done), 0);

      // Back-pressure on beat 7
      push_dump(1'b0);
      pulse_start();
      wait_beat(7);
      dut_if.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_hold", {dut_if.out_valid, dut_if.out_index, dut_if.out_data},
               {1'b1, AW'(7), WIDTH'(7)});
      end
      dut_if.out_ready = 1'b1;
      wait_done();

      // Write to X5 before its capture is visible
      push_dump(1'b1);
      pulse_start();
      wait_beat(2);
      regs[5] = 64'hDEAD;
      wait_done();
      regs[5] = 64'd5;

      // Write to X5 after beat 5 was accepted is not visible
      push_dump(1'b0);
      pulse_start();
      wait_beat(6);
      regs[5] = 64'hDEAD;
      wait_done();
      regs[5] = 64'd5;

      // start during SEND is ignored
      push_dump(1'b0);
      dc = done_cnt;
      pulse_start();
      wait_beat(10);
      pulse_start();
      wait_done();
      repeat (4) tick();
      check("single_done", EW'(done_cnt - dc), 1);
      check("idle_after", EW'(busy), 0);

      // Reset mid-dump aborts, then a new start begins at index 0
      push_dump(1'b0);
      dc = done_cnt;
      pulse_start();
      wait_beat(12);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("abort_valid", EW'(dut_if.out_valid), 0);
      check("abort_busy", EW'(busy), 0);
      check("abort_done", EW'(done), 0);
      exp_q.delete();
      repeat (3) tick();
      check("abort_no_done", EW'(done_cnt - dc), 0);
      push_dump(1'b0);
      pulse_start();
      tick();
      check("restart_index", {dut_if.out_valid, dut_if.out_index}, {1'b1, AW'(0)});
      wait_done();

      tick();
      check("queue_empty", EW'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
